// File: rtl/qspi_req_arbiter.sv
// Round-robin arbiter sharing one QSPI memory controller between two requesters.
// Define QSPI_ARB_AUTO_WREN_EN to prefix modifying opcodes with a 0x06 write-enable.
//
// state | meaning
// IDLE  | no owner; pick the next requester round-robin
// ISSUE | wait for the controller to go idle, then fire the trigger
// ACK   | wait for busy to rise, bounded by ACK_TIMEOUT
// BUSY  | wait for the controller to finish the transaction
// RESP  | done pulse to the owner, release the grant
module qspi_req_arbiter #(
    parameter int DATA_W      = 2072,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        req,
    input  logic [7:0]        cmd0,
    input  logic [7:0]        cmd1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    input  logic              quad0,
    input  logic              quad1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [7:0]        rsp_readout,
    output logic              rsp_error,
    output logic              ctl_trigger,
    output logic [7:0]        ctl_cmd,
    output logic [DATA_W-1:0] ctl_data,
    output logic              ctl_quad,
    input  logic              ctl_busy,
    input  logic [7:0]        ctl_readout,
    input  logic              ctl_error
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_ACK, S_BUSY, S_RESP} state_t;
    typedef enum logic {PH_CMD, PH_WREN} phase_t;

    localparam logic [7:0] OP_WREN  = 8'h06;
    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [7:0]  rsp_readout_q, rsp_readout_d;
    logic        rsp_error_q, rsp_error_d;
    logic        ctl_trigger_q, ctl_trigger_d;
    logic [7:0]  ctl_cmd_q, ctl_cmd_d;

    logic        pick_owner;
    logic        wren_needed;
    logic [7:0]  owner_cmd;
    logic [1:0]  owner_oh;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            phase_q       <= PH_CMD;
            owner_q       <= 1'b0;
            rr_q          <= 1'b0;
            tmo_q         <= '0;
            gnt_q         <= '0;
            done_q        <= '0;
            rsp_readout_q <= '0;
            rsp_error_q   <= 1'b0;
            ctl_trigger_q <= 1'b0;
            ctl_cmd_q     <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            owner_q       <= owner_d;
            rr_q          <= rr_d;
            tmo_q         <= tmo_d;
            gnt_q         <= gnt_d;
            done_q        <= done_d;
            rsp_readout_q <= rsp_readout_d;
            rsp_error_q   <= rsp_error_d;
            ctl_trigger_q <= ctl_trigger_d;
            ctl_cmd_q     <= ctl_cmd_d;
        end
    end

    always_comb begin
        pick_owner = req[rr_q] ? rr_q : ~rr_q;
        owner_cmd  = owner_q ? cmd1 : cmd0;
        owner_oh   = owner_q ? 2'b10 : 2'b01;
`ifdef QSPI_ARB_AUTO_WREN_EN
        wren_needed = (pick_owner ? cmd1 : cmd0) inside {8'h02, 8'hD8, 8'hC7, 8'h61};
`else
        wren_needed = 1'b0;
`endif
    end

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        owner_d       = owner_q;
        rr_d          = rr_q;
        tmo_d         = tmo_q;
        gnt_d         = gnt_q;
        done_d        = 2'b00;
        rsp_readout_d = rsp_readout_q;
        rsp_error_d   = rsp_error_q;
        ctl_trigger_d = 1'b0;
        ctl_cmd_d     = ctl_cmd_q;

        unique case (state_q)
            S_IDLE: begin
                if (|req) begin
                    owner_d = pick_owner;
                    gnt_d   = pick_owner ? 2'b10 : 2'b01;
                    phase_d = wren_needed ? PH_WREN : PH_CMD;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!ctl_busy) begin
                    ctl_trigger_d = 1'b1;
                    ctl_cmd_d     = (phase_q == PH_WREN) ? OP_WREN : owner_cmd;
                    tmo_d         = '0;
                    state_d       = S_ACK;
                end
            end
            S_ACK: begin
                tmo_d = tmo_q + 8'd1;
                if (ctl_busy) begin
                    state_d = S_BUSY;
                end else if (tmo_q == TMO_LAST) begin
                    // controller never acknowledged: report failure, skip any remaining phase
                    rsp_error_d   = 1'b1;
                    rsp_readout_d = '0;
                    done_d        = owner_oh;
                    state_d       = S_RESP;
                end
            end
            S_BUSY: begin
                if (!ctl_busy) begin
                    if (phase_q == PH_WREN && !ctl_error) begin
                        phase_d = PH_CMD;
                        state_d = S_ISSUE;
                    end else begin
                        rsp_readout_d = ctl_readout;
                        rsp_error_d   = ctl_error;
                        done_d        = owner_oh;
                        state_d       = S_RESP;
                    end
                end
            end
            S_RESP: begin
                gnt_d   = 2'b00;
                rr_d    = ~owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ctl_data = '0;
        ctl_quad = 1'b0;
        if (gnt_q[0]) begin
            ctl_data = data0;
            ctl_quad = quad0;
        end else if (gnt_q[1]) begin
            ctl_data = data1;
            ctl_quad = quad1;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign rsp_readout = rsp_readout_q;
    assign rsp_error   = rsp_error_q;
    assign ctl_trigger = ctl_trigger_q;
    assign ctl_cmd     = ctl_cmd_q;

endmodule
